// File: rtl/nibbler_button_port.sv
// Nibbler pushbutton IN-port: 2-flop sync, per-bit debounce, sticky press flags read-and-clear by the uP.
// Press reaches stable 2+DEBOUNCE_CYCLES clocks after sampling (3 clocks when BTN_DEBOUNCE_EN is undefined).
module nibbler_button_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pushbuttons,
    input  logic       phase,
    input  logic       rd_en,
    output logic [3:0] data_bus,
    output logic       pending,
    output logic [3:0] stable
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
        $error("nibbler_button_port: DEBOUNCE_CYCLES must be 1..15");
    end

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] stable_q;
    logic [3:0] stable_d;
    logic [3:0] flag_q;
    logic [3:0] flag_d;
    logic       rd_cycle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= pushbuttons;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0] cnt_q [4];
    logic [3:0] cnt_d [4];

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = 4'd0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign stable_d = sync2_q;
`endif

    assign rd_cycle = phase & rd_en;

    // A press landing on the read edge survives the clear.
    assign flag_d = (rd_cycle ? 4'b0000 : flag_q) | (stable_d & ~stable_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q <= 4'b0000;
            flag_q   <= 4'b0000;
        end else begin
            stable_q <= stable_d;
            flag_q   <= flag_d;
        end
    end

    assign data_bus = rd_cycle ? flag_q : 4'b0000;
    assign pending  = |flag_q;
    assign stable   = stable_q;

endmodule

// File: tb/tb_nibbler_button_port.sv
// Directed bench for nibbler_button_port; expectations follow whether BTN_DEBOUNCE_EN is defined.
module tb_nibbler_button_port;

    localparam int DC = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int         LAT        = 2 + DC;
    localparam logic [3:0] EXP_GLITCH = 4'b0000;
    localparam logic [3:0] EXP_SPIKE3 = 4'b0000;
`else
    localparam int         LAT        = 3;
    localparam logic [3:0] EXP_GLITCH = 4'b0001;
    localparam logic [3:0] EXP_SPIKE3 = 4'b1000;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] pushbuttons;
    logic       phase;
    logic       rd_en;
    logic [3:0] data_bus;
    logic       pending;
    logic [3:0] stable;

    int n_checks = 0;
    int n_errors = 0;

    nibbler_button_port #(.DEBOUNCE_CYCLES(DC)) dut (
        .clock       (clock),
        .reset       (reset),
        .pushbuttons (pushbuttons),
        .phase       (phase),
        .rd_en       (rd_en),
        .data_bus    (data_bus),
        .pending     (pending),
        .stable      (stable)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        pushbuttons = 4'b1111;
        phase       = 1'b0;
        rd_en       = 1'b0;
        #1;
        check("rst_stable_async", stable, 4'b0000);
        tick(3);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("rst_data_bus", data_bus, 4'b0000);
        check("rst_pending", {3'b000, pending}, 4'b0000);
        check("rst_stable", stable, 4'b0000);
        phase = 1'b0;
        rd_en = 1'b0;

        // Button held across reset release is a fresh press.
        reset = 1'b0;
        tick(LAT - 1);
        check("rel_stable_early", stable, 4'b0000);
        check("rel_pending_early", {3'b000, pending}, 4'b0000);
        tick(1);
        check("rel_stable", stable, 4'b1111);
        check("rel_pending", {3'b000, pending}, 4'b0001);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("rel_read", data_bus, 4'b1111);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;
        #1;
        check("rel_after_read_pend", {3'b000, pending}, 4'b0000);
        check("idle_data_bus", data_bus, 4'b0000);

        // Releases never raise flags.
        pushbuttons = 4'b0000;
        tick(LAT);
        check("release_stable", stable, 4'b0000);
        check("release_pending", {3'b000, pending}, 4'b0000);

        // Single press, then back-to-back reads.
        pushbuttons = 4'b0100;
        tick(LAT);
        check("b2_stable", stable, 4'b0100);
        check("b2_pending", {3'b000, pending}, 4'b0001);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("b2_read1", data_bus, 4'b0100);
        tick(1);
        check("b2_read2", data_bus, 4'b0000);
        check("b2_pend_after", {3'b000, pending}, 4'b0000);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;
        pushbuttons = 4'b0000;
        tick(LAT + 1);

        // Two-clock pulse on button 0.
        pushbuttons = 4'b0001;
        tick(2);
        pushbuttons = 4'b0000;
        tick(10);
        check("glitch_stable", stable, 4'b0000);
        check("glitch_pending", {3'b000, pending}, {3'b000, EXP_GLITCH[0]});
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("glitch_read", data_bus, EXP_GLITCH);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;

        // Press of button 1 lands on the read edge while flag 3 is set.
        pushbuttons = 4'b1000;
        tick(LAT);
        check("b3_pending", {3'b000, pending}, 4'b0001);
        pushbuttons = 4'b1010;
        tick(LAT - 1);
        check("coinc_stable_pre", stable, 4'b1000);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("coinc_read", data_bus, 4'b1000);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;
        #1;
        check("coinc_stable", stable, 4'b1010);
        check("coinc_pending", {3'b000, pending}, 4'b0001);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("coinc_flag", data_bus, 4'b0010);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;
        pushbuttons = 4'b0000;
        tick(LAT + 1);

        // rd_en during fetch phase is ignored.
        pushbuttons = 4'b0001;
        tick(LAT);
        rd_en = 1'b1;
        #1;
        check("fetch_data_bus", data_bus, 4'b0000);
        tick(1);
        check("fetch_pending", {3'b000, pending}, 4'b0001);
        phase = 1'b1;
        #1;
        check("exec_read", data_bus, 4'b0001);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;
        #1;
        check("exec_pend_after", {3'b000, pending}, 4'b0000);

        // One-clock spike on button 3 while button 0 stays held.
        pushbuttons = 4'b1001;
        tick(1);
        pushbuttons = 4'b0001;
        tick(8);
        check("spike_stable", stable, 4'b0001);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("spike_read", data_bus, EXP_SPIKE3);
        tick(1);
        phase = 1'b0;
        rd_en = 1'b0;

        // Reset with a flag pending and a debounce in flight discards everything.
        pushbuttons = 4'b0011;
        tick(LAT);
        check("pre_rst_pending", {3'b000, pending}, 4'b0001);
        pushbuttons = 4'b0111;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_stable", stable, 4'b0000);
        check("mid_rst_pending", {3'b000, pending}, 4'b0000);
        pushbuttons = 4'b0000;
        tick(2);
        reset = 1'b0;
        tick(10);
        check("post_rst_pending", {3'b000, pending}, 4'b0000);
        phase = 1'b1;
        rd_en = 1'b1;
        #1;
        check("post_rst_read", data_bus, 4'b0000);
        tick(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
